// File: rtl/serial_uart_bridge_pkg.sv
// serial_uart_bridge_pkg
//   Shared constants for the serial UART bridge: UART FSM state encodings
//   (2 bits, used by both the TX and RX state machines), the default bit
//   period and the number of data bits per frame (8 data, 1 stop, no parity).
package serial_uart_bridge_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    // 50 MHz system clock, 115200 baud.
    localparam int DEFAULT_CLKS_PER_BIT = 434;

    localparam int DATA_BITS = 8;

endpackage

// File: rtl/serial_uart_bridge_byte_fifo.sv
// serial_uart_bridge_byte_fifo
//   Count-based byte FIFO with first-word-fall-through output: dout_out
//   always shows the head entry and is meaningful whenever empty_out=0.
//   Storage is registered, so a byte pushed into an empty FIFO is visible
//   (and empty_out drops) on the cycle after the push.
// Ports
//   clock, reset   clock and asynchronous active-high reset
//   push_in        write din_in this cycle (ignored when full unless popping)
//   pop_in         drop the head entry this cycle (ignored when empty)
//   din_in         byte to write
//   dout_out       head byte
//   full_out       DEPTH entries held
//   empty_out      no entries held
module serial_uart_bridge_byte_fifo #(
    parameter int DEPTH = 8,
    parameter int PTR_W = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       push_in,
    input  logic       pop_in,
    input  logic [7:0] din_in,
    output logic [7:0] dout_out,
    output logic       full_out,
    output logic       empty_out
);

    logic [7:0]       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push, do_pop;

    assign full_out  = (count_q == (PTR_W+1)'(DEPTH));
    assign empty_out = (count_q == '0);
    assign dout_out  = mem_q[rd_ptr_q];

    // A pop at full frees the slot the simultaneous push lands in.
    assign do_pop  = pop_in && !empty_out;
    assign do_push = push_in && (!full_out || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            // Cleared so the head byte reads 0 out of reset.
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (do_push) mem_q[wr_ptr_q] <= din_in;
        end
    end

endmodule

// File: rtl/serial_uart_bridge.sv
// serial_uart_bridge
//   Peripheral end of the processor's byte-wide serial port. CPU writes are
//   buffered in a TX FIFO and sent as 8N1 UART on uart_txd_out; bytes
//   received on uart_rxd_in land in an RX FIFO read back first-word-fall-
//   through.
// Handshake: a CPU write is taken on any clock edge where cpu_wren_in=1 and
//   cpu_ready_out=1 (writes while not ready are dropped); a CPU read pops on
//   any edge where cpu_rden_in=1 and cpu_valid_out=1, and cpu_data_out holds
//   the head byte whenever cpu_valid_out=1. Both flags come straight from the
//   FIFO counts.
// Ports
//   clock, reset              clock and asynchronous active-high reset
//   cpu_data_in/wren_in       byte to transmit and its write strobe
//   cpu_ready_out             TX FIFO not full
//   cpu_rden_in               pop RX FIFO head
//   cpu_data_out/valid_out    RX FIFO head and not-empty flag
//   uart_rxd_in               asynchronous serial input, idle high
//   uart_txd_out              registered serial output, idle high
//   rx_overrun_out            sticky: received byte dropped, RX FIFO full
//   rx_frame_err_out          sticky: stop bit sampled low
//   dbg_tx_state_out          TX FSM state
//   dbg_rx_state_out          RX FSM state
module serial_uart_bridge
    import serial_uart_bridge_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 8,
    parameter int PTR_W        = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] cpu_data_in,
    input  logic       cpu_wren_in,
    output logic       cpu_ready_out,
    input  logic       cpu_rden_in,
    output logic [7:0] cpu_data_out,
    output logic       cpu_valid_out,
    input  logic       uart_rxd_in,
    output logic       uart_txd_out,
    output logic       rx_overrun_out,
    output logic       rx_frame_err_out,
    output logic [1:0] dbg_tx_state_out,
    output logic [1:0] dbg_rx_state_out
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] BAUD_HALF = BAUD_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [2:0]        BIT_LAST  = 3'(DATA_BITS - 1);

    // ---------------- FIFOs ----------------
    logic       tx_pop, tx_full, tx_empty;
    logic [7:0] tx_dout;
    logic       rx_push, rx_full, rx_empty;

    serial_uart_bridge_byte_fifo #(.DEPTH(FIFO_DEPTH), .PTR_W(PTR_W)) u_tx_fifo (
        .clock     (clock),
        .reset     (reset),
        .push_in   (cpu_wren_in),
        .pop_in    (tx_pop),
        .din_in    (cpu_data_in),
        .dout_out  (tx_dout),
        .full_out  (tx_full),
        .empty_out (tx_empty)
    );

    serial_uart_bridge_byte_fifo #(.DEPTH(FIFO_DEPTH), .PTR_W(PTR_W)) u_rx_fifo (
        .clock     (clock),
        .reset     (reset),
        .push_in   (rx_push),
        .pop_in    (cpu_rden_in),
        .din_in    (rx_shift_q),
        .dout_out  (cpu_data_out),
        .full_out  (rx_full),
        .empty_out (rx_empty)
    );

    assign cpu_ready_out = !tx_full;
    assign cpu_valid_out = !rx_empty;

    // ---------------- TX ----------------
    logic [1:0]        tx_state_q, tx_state_d;
    logic [BAUD_W-1:0] tx_baud_q, tx_baud_d;
    logic [2:0]        tx_bit_q, tx_bit_d;
    logic [7:0]        tx_shift_q, tx_shift_d;
    logic              txd_q, txd_d;
    logic              tx_baud_end;

    assign tx_baud_end = (tx_baud_q == BAUD_LAST);

    always_comb begin
        tx_state_d = tx_state_q;
        tx_baud_d  = tx_baud_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_pop     = 1'b0;
        case (tx_state_q)
            ST_IDLE: begin
                if (!tx_empty) begin
                    tx_pop     = 1'b1;
                    tx_shift_d = tx_dout;
                    tx_baud_d  = '0;
                    tx_bit_d   = '0;
                    tx_state_d = ST_START;
                end
            end
            ST_START: begin
                if (tx_baud_end) begin
                    tx_baud_d  = '0;
                    tx_state_d = ST_DATA;
                end else begin
                    tx_baud_d = tx_baud_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (tx_baud_end) begin
                    tx_baud_d  = '0;
                    tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    if (tx_bit_q == BIT_LAST) begin
                        tx_bit_d   = '0;
                        tx_state_d = ST_STOP;
                    end else begin
                        tx_bit_d = tx_bit_q + 1'b1;
                    end
                end else begin
                    tx_baud_d = tx_baud_q + 1'b1;
                end
            end
            default: begin // ST_STOP
                if (tx_baud_end) begin
                    tx_baud_d = '0;
                    // Chain straight into the next start bit with no idle gap.
                    if (!tx_empty) begin
                        tx_pop     = 1'b1;
                        tx_shift_d = tx_dout;
                        tx_state_d = ST_START;
                    end else begin
                        tx_state_d = ST_IDLE;
                    end
                end else begin
                    tx_baud_d = tx_baud_q + 1'b1;
                end
            end
        endcase
    end

    // Line level is a registered copy of the current state's bit, so the
    // output lags the FSM by one clock.
    always_comb begin
        case (tx_state_q)
            ST_START: txd_d = 1'b0;
            ST_DATA:  txd_d = tx_shift_q[0];
            default:  txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tx_state_q <= ST_IDLE;
            tx_baud_q  <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            txd_q      <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_baud_q  <= tx_baud_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            txd_q      <= txd_d;
        end
    end

    assign uart_txd_out     = txd_q;
    assign dbg_tx_state_out = tx_state_q;

    // ---------------- RX ----------------
    logic [1:0]        sync_q;
    logic              rxs;
    logic [1:0]        rx_state_q, rx_state_d;
    logic [BAUD_W-1:0] rx_baud_q, rx_baud_d;
    logic [2:0]        rx_bit_q, rx_bit_d;
    logic [7:0]        rx_shift_q, rx_shift_d;
    logic              overrun_q, overrun_d;
    logic              frame_err_q, frame_err_d;
    logic              rx_baud_end;

    assign rxs         = sync_q[1];
    assign rx_baud_end = (rx_baud_q == BAUD_LAST);

    always_comb begin
        rx_state_d  = rx_state_q;
        rx_baud_d   = rx_baud_q;
        rx_bit_d    = rx_bit_q;
        rx_shift_d  = rx_shift_q;
        overrun_d   = overrun_q;
        frame_err_d = frame_err_q;
        rx_push     = 1'b0;
        case (rx_state_q)
            ST_IDLE: begin
                if (!rxs) begin
                    rx_baud_d  = '0;
                    rx_state_d = ST_START;
                end
            end
            ST_START: begin
                // Re-check at mid start bit; a line back high was a glitch.
                if (rx_baud_q == BAUD_HALF) begin
                    rx_baud_d  = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rxs ? ST_IDLE : ST_DATA;
                end else begin
                    rx_baud_d = rx_baud_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (rx_baud_end) begin
                    rx_baud_d  = '0;
                    rx_shift_d = {rxs, rx_shift_q[7:1]};
                    if (rx_bit_q == BIT_LAST) begin
                        rx_bit_d   = '0;
                        rx_state_d = ST_STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + 1'b1;
                    end
                end else begin
                    rx_baud_d = rx_baud_q + 1'b1;
                end
            end
            default: begin // ST_STOP
                // Leave at stop-bit centre so the next start edge is caught.
                if (rx_baud_end) begin
                    rx_baud_d  = '0;
                    rx_state_d = ST_IDLE;
                    if (!rxs)         frame_err_d = 1'b1;
                    else if (rx_full) overrun_d   = 1'b1;
                    else              rx_push     = 1'b1;
                end else begin
                    rx_baud_d = rx_baud_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q      <= 2'b11;
            rx_state_q  <= ST_IDLE;
            rx_baud_q   <= '0;
            rx_bit_q    <= '0;
            rx_shift_q  <= '0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            sync_q      <= {sync_q[0], uart_rxd_in};
            rx_state_q  <= rx_state_d;
            rx_baud_q   <= rx_baud_d;
            rx_bit_q    <= rx_bit_d;
            rx_shift_q  <= rx_shift_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign rx_overrun_out   = overrun_q;
    assign rx_frame_err_out = frame_err_q;
    assign dbg_rx_state_out = rx_state_q;

endmodule

// File: tb/tb_serial_uart_bridge.sv
module tb_serial_uart_bridge;
    import serial_uart_bridge_pkg::*;

    localparam int CPB = 8;

    // ---------------- clock / reset ----------------
    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] cpu_data_in = 8'h00;
    logic       cpu_wren_in = 1'b0;
    logic       cpu_rden_in = 1'b0;
    logic       uart_rxd_in = 1'b1;
    logic       cpu_ready_out, cpu_valid_out, uart_txd_out;
    logic [7:0] cpu_data_out;
    logic       rx_overrun_out, rx_frame_err_out;
    logic [1:0] dbg_tx_state_out, dbg_rx_state_out;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    serial_uart_bridge #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4), .PTR_W(2)) dut (
        .clock            (clock),
        .reset            (reset),
        .cpu_data_in      (cpu_data_in),
        .cpu_wren_in      (cpu_wren_in),
        .cpu_ready_out    (cpu_ready_out),
        .cpu_rden_in      (cpu_rden_in),
        .cpu_data_out     (cpu_data_out),
        .cpu_valid_out    (cpu_valid_out),
        .uart_rxd_in      (uart_rxd_in),
        .uart_txd_out     (uart_txd_out),
        .rx_overrun_out   (rx_overrun_out),
        .rx_frame_err_out (rx_frame_err_out),
        .dbg_tx_state_out (dbg_tx_state_out),
        .dbg_rx_state_out (dbg_rx_state_out)
    );

    // ---------------- driver tasks ----------------
    // Advance n clock edges and land 1 ns after the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // One 8N1 frame on the rx line, LSB first, then back to idle.
    task automatic drive_rx(input logic [7:0] b, input logic stop_bit);
        uart_rxd_in = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            uart_rxd_in = b[i];
            tick(CPB);
        end
        uart_rxd_in = stop_bit;
        tick(CPB);
        uart_rxd_in = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        tick(3);
        checks++; if (cpu_ready_out !== 1'b1) begin errors++; $display("FAIL rst_ready got %b want 1", cpu_ready_out); end
        checks++; if (cpu_valid_out !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", cpu_valid_out); end
        checks++; if (cpu_data_out !== 8'h00) begin errors++; $display("FAIL rst_data got %h want 00", cpu_data_out); end
        checks++; if (uart_txd_out !== 1'b1) begin errors++; $display("FAIL rst_txd got %b want 1", uart_txd_out); end
        checks++; if ({rx_overrun_out, rx_frame_err_out} !== 2'b00) begin errors++; $display("FAIL rst_sticky got %b want 00", {rx_overrun_out, rx_frame_err_out}); end
        reset = 1'b0;
        tick(3);
        checks++; if ({dbg_tx_state_out, dbg_rx_state_out} !== {ST_IDLE, ST_IDLE}) begin errors++; $display("FAIL rst_fsm got %b want 0000", {dbg_tx_state_out, dbg_rx_state_out}); end
        checks++; if (uart_txd_out !== 1'b1) begin errors++; $display("FAIL post_rst_txd got %b want 1", uart_txd_out); end
    endtask

    task automatic test_tx_single();
        logic [9:0] exp_frm;
        logic [9:0] got_frm;
        int         rdy_bad;
        exp_frm = {1'b1, 8'hA5, 1'b0};  // stop, data, start (bit 0 goes out first)
        got_frm = '0;
        rdy_bad = 0;
        cpu_data_in = 8'hA5;
        cpu_wren_in = 1'b1;
        tick(1);                        // edge N
        cpu_wren_in = 1'b0;
        tick(1);                        // edge N+1
        checks++; if (uart_txd_out !== 1'b1) begin errors++; $display("FAIL tx_n1_idle got %b want 1", uart_txd_out); end
        tick(1);                        // edge N+2
        checks++; if (uart_txd_out !== 1'b0) begin errors++; $display("FAIL tx_n2_start got %b want 0", uart_txd_out); end
        tick(4);                        // centre of start bit
        for (int k = 0; k < 10; k++) begin
            got_frm[k] = uart_txd_out;
            for (int j = 0; j < CPB; j++) begin
                if (cpu_ready_out !== 1'b1) rdy_bad++;
                tick(1);
            end
        end
        checks++; if (got_frm !== exp_frm) begin errors++; $display("FAIL tx_a5_frame got %b want %b", got_frm, exp_frm); end
        checks++; if (rdy_bad !== 0) begin errors++; $display("FAIL tx_ready_held got %0d low cycles want 0", rdy_bad); end
        checks++; if (uart_txd_out !== 1'b1) begin errors++; $display("FAIL tx_after_idle got %b want 1", uart_txd_out); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes [6];
        logic [9:0] got_frm [5];
        logic [9:0] exp_frm;
        bytes = '{8'h01, 8'h80, 8'hFF, 8'h00, 8'h5A, 8'hC3};
        for (int f = 0; f < 5; f++) got_frm[f] = '0;
        cpu_data_in = bytes[0];
        cpu_wren_in = 1'b1;
        tick(1);                        // edge N
        for (int i = 1; i < 6; i++) begin
            cpu_data_in = bytes[i];
            if (i == 4) begin
                checks++; if (cpu_ready_out !== 1'b1) begin errors++; $display("FAIL b2b_ready_w5 got %b want 1", cpu_ready_out); end
            end
            if (i == 5) begin
                checks++; if (cpu_ready_out !== 1'b0) begin errors++; $display("FAIL b2b_ready_full got %b want 0", cpu_ready_out); end
            end
            tick(1);
        end
        cpu_wren_in = 1'b0;
        tick(1);                        // edge N+6: centre of first start bit
        for (int k = 0; k < 50; k++) begin
            got_frm[k / 10][k % 10] = uart_txd_out;
            tick(CPB);
        end
        for (int f = 0; f < 5; f++) begin
            exp_frm = {1'b1, bytes[f], 1'b0};
            checks++; if (got_frm[f] !== exp_frm) begin errors++; $display("FAIL b2b_frame%0d got %b want %b", f, got_frm[f], exp_frm); end
        end
        tick(20);                       // a 6th frame would be in its data bits here
        checks++; if (uart_txd_out !== 1'b1) begin errors++; $display("FAIL b2b_no_sixth got %b want 1", uart_txd_out); end
        checks++; if (dbg_tx_state_out !== ST_IDLE) begin errors++; $display("FAIL b2b_tx_idle got %0d want 0", dbg_tx_state_out); end
        checks++; if (cpu_ready_out !== 1'b1) begin errors++; $display("FAIL b2b_ready_drained got %b want 1", cpu_ready_out); end
    endtask

    task automatic test_rx_single();
        drive_rx(8'h3C, 1'b1);
        checks++; if (cpu_valid_out !== 1'b1) begin errors++; $display("FAIL rx_valid got %b want 1", cpu_valid_out); end
        checks++; if (cpu_data_out !== 8'h3C) begin errors++; $display("FAIL rx_data got %h want 3c", cpu_data_out); end
        cpu_rden_in = 1'b1;
        tick(1);
        cpu_rden_in = 1'b0;
        checks++; if (cpu_valid_out !== 1'b0) begin errors++; $display("FAIL rx_popped got %b want 0", cpu_valid_out); end
        checks++; if ({rx_overrun_out, rx_frame_err_out} !== 2'b00) begin errors++; $display("FAIL rx_sticky got %b want 00", {rx_overrun_out, rx_frame_err_out}); end
    endtask

    task automatic test_rx_overrun();
        logic [7:0] exp_q [$];
        logic [7:0] bytes [5];
        logic [7:0] exp_b;
        bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        for (int i = 0; i < 5; i++) begin
            drive_rx(bytes[i], 1'b1);
            if (i < 4) exp_q.push_back(bytes[i]);   // 5th is dropped
            tick(2);
        end
        checks++; if (rx_overrun_out !== 1'b1) begin errors++; $display("FAIL ovr_flag got %b want 1", rx_overrun_out); end
        checks++; if (rx_frame_err_out !== 1'b0) begin errors++; $display("FAIL ovr_frame_err got %b want 0", rx_frame_err_out); end
        while (exp_q.size() > 0) begin
            exp_b = exp_q.pop_front();
            checks++; if (cpu_valid_out !== 1'b1 || cpu_data_out !== exp_b) begin errors++; $display("FAIL ovr_read got v=%b %h want v=1 %h", cpu_valid_out, cpu_data_out, exp_b); end
            cpu_rden_in = 1'b1;
            tick(1);
            cpu_rden_in = 1'b0;
        end
        checks++; if (cpu_valid_out !== 1'b0) begin errors++; $display("FAIL ovr_empty got %b want 0", cpu_valid_out); end
    endtask

    task automatic test_rx_errors();
        uart_rxd_in = 1'b0;
        tick(2);
        uart_rxd_in = 1'b1;
        tick(20);
        checks++; if (cpu_valid_out !== 1'b0) begin errors++; $display("FAIL glitch_valid got %b want 0", cpu_valid_out); end
        checks++; if (dbg_rx_state_out !== ST_IDLE) begin errors++; $display("FAIL glitch_rx_idle got %0d want 0", dbg_rx_state_out); end
        checks++; if (rx_frame_err_out !== 1'b0) begin errors++; $display("FAIL glitch_frame_err got %b want 0", rx_frame_err_out); end
        drive_rx(8'h81, 1'b0);
        tick(10);
        checks++; if (cpu_valid_out !== 1'b0) begin errors++; $display("FAIL ferr_valid got %b want 0", cpu_valid_out); end
        checks++; if (rx_frame_err_out !== 1'b1) begin errors++; $display("FAIL ferr_flag got %b want 1", rx_frame_err_out); end
    endtask

    task automatic test_reset_midframe();
        drive_rx(8'h77, 1'b1);
        tick(2);
        checks++; if (cpu_valid_out !== 1'b1) begin errors++; $display("FAIL mid_pre_valid got %b want 1", cpu_valid_out); end
        cpu_data_in = 8'h96;
        cpu_wren_in = 1'b1;
        tick(1);                        // edge N
        cpu_wren_in = 1'b0;
        tick(20);
        uart_rxd_in = 1'b0;             // start of an rx frame
        tick(20);                       // N+40: tx sends data bit 3 of 0x96 = 0
        checks++; if (uart_txd_out !== 1'b0) begin errors++; $display("FAIL mid_pre_txd got %b want 0", uart_txd_out); end
        checks++; if (dbg_rx_state_out !== ST_DATA) begin errors++; $display("FAIL mid_pre_rx got %0d want 2", dbg_rx_state_out); end
        #2 reset = 1'b1;
        #1;
        checks++; if (uart_txd_out !== 1'b1) begin errors++; $display("FAIL mid_rst_txd got %b want 1", uart_txd_out); end
        checks++; if (cpu_valid_out !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got %b want 0", cpu_valid_out); end
        checks++; if (cpu_ready_out !== 1'b1) begin errors++; $display("FAIL mid_rst_ready got %b want 1", cpu_ready_out); end
        checks++; if ({rx_overrun_out, rx_frame_err_out} !== 2'b00) begin errors++; $display("FAIL mid_rst_sticky got %b want 00", {rx_overrun_out, rx_frame_err_out}); end
        tick(2);
        reset = 1'b0;
        uart_rxd_in = 1'b1;
        tick(100);
        checks++; if (uart_txd_out !== 1'b1 || dbg_tx_state_out !== ST_IDLE) begin errors++; $display("FAIL mid_after_tx got txd=%b st=%0d want 1 0", uart_txd_out, dbg_tx_state_out); end
        checks++; if (cpu_valid_out !== 1'b0) begin errors++; $display("FAIL mid_after_valid got %b want 0", cpu_valid_out); end
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        test_reset();
        test_tx_single();
        test_back_to_back();
        test_rx_single();
        test_rx_overrun();
        test_rx_errors();
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard stop in case something stalls the sequence.
    initial begin
        #200000;
        $display("FAIL timeout got stalled want finished");
        $fatal(1, "timeout");
    end

endmodule
